// File: rtl/lwe_decrypt_core_if.sv
// Handshake bundle between the ciphertext/key read path and the LWE decryption core.
// Noise monitor signals exist only when LWE_DECRYPT_NOISE_MON_EN is defined.
interface lwe_decrypt_core_if #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10
) ();
  logic                        start;
  logic                        in_valid;
  logic                        in_ready;
  logic [CIPHERTEXT_WIDTH-1:0] in_a;
  logic [CIPHERTEXT_WIDTH-1:0] in_s;
  logic                        out_valid;
  logic                        out_ready;
  logic [PLAINTEXT_WIDTH-1:0]  out_data;
  logic                        busy;
`ifdef LWE_DECRYPT_NOISE_MON_EN
  logic [CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH:0] noise_out;
  logic                                      noise_warn;

  modport master (
    output start, in_valid, in_a, in_s, out_ready,
    input  in_ready, out_valid, out_data, busy, noise_out, noise_warn
  );
  modport slave (
    input  start, in_valid, in_a, in_s, out_ready,
    output in_ready, out_valid, out_data, busy, noise_out, noise_warn
  );
`else
  modport master (
    output start, in_valid, in_a, in_s, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  start, in_valid, in_a, in_s, out_ready,
    output in_ready, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/lwe_decrypt_core.sv
// Streaming LWE decryption: plaintext = round_p(b - <a,s> mod q), valid/ready result.
// Optional noise monitor (noise_out/noise_warn) enabled by LWE_DECRYPT_NOISE_MON_EN.
//
// state | meaning
// IDLE  | waiting for a start pulse
// ACCUM | accepting DIMENSION (a_i, s_i) beats into acc
// BVAL  | accepting the b beat and rounding the difference
// OUT   | holding the result until out_ready
module lwe_decrypt_core #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int DIM_WIDTH          = 4
) (
  input logic               clk,
  input logic               rst_n,
  lwe_decrypt_core_if.slave bus
);
  localparam int SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
  localparam logic [CIPHERTEXT_WIDTH-1:0] HALF_STEP =
    CIPHERTEXT_WIDTH'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));
  localparam logic [DIM_WIDTH-1:0] LAST_IDX = DIM_WIDTH'(DIMENSION - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, BVAL, OUT} state_t;

  state_t                      state_q;
  logic [CIPHERTEXT_WIDTH-1:0] acc_q;
  logic [DIM_WIDTH-1:0]        cnt_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [PLAINTEXT_WIDTH-1:0]  out_data_q;
  logic                        busy_q;

  logic                        in_beat;
  logic [CIPHERTEXT_WIDTH-1:0] prod;
  logic [CIPHERTEXT_WIDTH-1:0] acc_d;
  logic [CIPHERTEXT_WIDTH-1:0] diff;
  logic [PLAINTEXT_WIDTH-1:0]  round_d;

  assign in_beat = bus.in_valid & in_ready_q;
  // Product and sums are kept at CIPHERTEXT_WIDTH so everything wraps mod q.
  assign prod    = bus.in_a * bus.in_s;
  assign acc_d   = acc_q + prod;
  assign diff    = bus.in_a - acc_q;
  assign round_d = PLAINTEXT_WIDTH'((diff + HALF_STEP) >> SHIFT);

`ifdef LWE_DECRYPT_NOISE_MON_EN
  localparam int NW = SHIFT + 1;
  localparam logic [NW-1:0] QUARTER_STEP = NW'(CIPHERTEXT_MODULUS / (4 * PLAINTEXT_MODULUS));

  logic [NW-1:0] noise_q;
  logic          noise_warn_q;
  logic [NW-1:0] noise_d;
  logic [NW-1:0] noise_abs;
  logic          noise_warn_d;

  // Residual always fits in NW signed bits, so truncation is the sign-extended value.
  assign noise_d      = NW'(diff - {round_d, {SHIFT{1'b0}}});
  assign noise_abs    = noise_d[NW-1] ? -noise_d : noise_d;
  assign noise_warn_d = (noise_abs >= QUARTER_STEP);

  assign bus.noise_out  = noise_q;
  assign bus.noise_warn = noise_warn_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef LWE_DECRYPT_NOISE_MON_EN
      noise_q      <= '0;
      noise_warn_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + DIM_WIDTH'(1);
            if (cnt_q == LAST_IDX) state_q <= BVAL;
          end
        end
        BVAL: begin
          if (in_beat) begin
            out_data_q  <= round_d;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= OUT;
`ifdef LWE_DECRYPT_NOISE_MON_EN
            noise_q      <= noise_d;
            noise_warn_q <= noise_warn_d;
`endif
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lwe_decrypt_core.sv
// Directed bench for lwe_decrypt_core: vector table plus backpressure and mid-op reset sequences.
// Noise monitor checks compile in when LWE_DECRYPT_NOISE_MON_EN is defined.
module tb_lwe_decrypt_core;
  localparam int PW  = 6;
  localparam int CW  = 10;
  localparam int DIM = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lwe_decrypt_core_if #(.PLAINTEXT_WIDTH(PW), .CIPHERTEXT_WIDTH(CW)) bus ();

  lwe_decrypt_core #(
    .PLAINTEXT_MODULUS(64), .PLAINTEXT_WIDTH(PW),
    .CIPHERTEXT_MODULUS(1024), .CIPHERTEXT_WIDTH(CW),
    .DIMENSION(DIM), .DIM_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [CW-1:0] a;
    logic [CW-1:0] s;
    logic [CW-1:0] b;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t vecs[6];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [CW-1:0] a, input logic [CW-1:0] s, output bit ok);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_s     = s;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    ok = bus.in_ready;
    if (ok) tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_decrypt(input logic [CW-1:0] a, input logic [CW-1:0] s,
                             input logic [CW-1:0] b, output logic [PW-1:0] got);
    bit ok;
    // Junk beat alongside start must be ignored in IDLE.
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 10'd5;
    bus.in_s     = 10'd7;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < DIM; i++) begin
      send_beat(a, s, ok);
      if (!ok) chk("accum_beat_timeout", 0, 1);
    end
    chk("out_valid_before_b", bus.out_valid, 0);
    send_beat(b, 10'd0, ok);
    if (!ok) chk("b_beat_timeout", 0, 1);
    chk("out_valid_latency", bus.out_valid, 1);
    chk("in_ready_in_out", bus.in_ready, 0);
    got = bus.out_data;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", bus.out_valid, 0);
    chk("busy_after_hs", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] got;
    bit ok;

    vecs[0] = '{a: 10'd7,    s: 10'd0,   b: 10'd80,   exp: 6'd5};
    vecs[1] = '{a: 10'd1,    s: 10'd1,   b: 10'd58,   exp: 6'd3};
    vecs[2] = '{a: 10'd1023, s: 10'd1,   b: 10'd1010, exp: 6'd0};
    vecs[3] = '{a: 10'd1023, s: 10'd1,   b: 10'd1005, exp: 6'd63};
    vecs[4] = '{a: 10'd3,    s: 10'd5,   b: 10'd470,  exp: 6'd20};
    vecs[5] = '{a: 10'd100,  s: 10'd100, b: 10'd648,  exp: 6'd63};

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_s = '0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_decrypt(vecs[v].a, vecs[v].s, vecs[v].b, got);
      chk($sformatf("vec%0d_out_data", v), got, vecs[v].exp);
      release_result();
      tick();
    end

    // Backpressure: result held, start during OUT ignored.
    run_decrypt(10'd1, 10'd1, 10'd58, got);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 1);
      tick();
      bus.start = 1'b0;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 3);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    release_result();
    tick();
    chk("bp_start_ignored_in_ready", bus.in_ready, 0);
    chk("bp_start_ignored_busy", bus.busy, 0);

    // Reset after 4 ACCUM beats discards the partial accumulation.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(10'd9, 10'd9, ok);
      if (!ok) chk("rst_accum_beat_timeout", 0, 1);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    tick();
    run_decrypt(10'd1, 10'd1, 10'd58, got);
    chk("after_rst_out_data", got, 3);
    release_result();
    tick();

`ifdef LWE_DECRYPT_NOISE_MON_EN
    run_decrypt(10'd1, 10'd1, 10'd63, got);
    chk("noise53_out_data", got, 3);
    chk("noise53_noise_out", int'($signed(bus.noise_out)), 5);
    chk("noise53_warn", bus.noise_warn, 1);
    release_result();
    tick();
    run_decrypt(10'd1, 10'd1, 10'd60, got);
    chk("noise50_out_data", got, 3);
    chk("noise50_noise_out", int'($signed(bus.noise_out)), 2);
    chk("noise50_warn", bus.noise_warn, 0);
    release_result();
    tick();
    run_decrypt(10'd1, 10'd1, 10'd50, got);
    chk("noise40_out_data", got, 3);
    chk("noise40_noise_out", int'($signed(bus.noise_out)), -8);
    chk("noise40_warn", bus.noise_warn, 1);
    release_result();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lwe_decrypt_core.md
Name: lwe_decrypt_core

Overview:
- Streaming LWE decryption stage, fed by the ciphertext/key SRAM read path inside the accelerator top.
- Consumes DIMENSION (a_i, s_i) pairs, then one b element.
- Computes diff = b - <a,s> mod q, rounds diff to a plaintext mod p, and presents the result on a valid/ready output.
- The result is consumed by the output-register/Wishbone readback logic.

Parameters:
- PLAINTEXT_MODULUS, 64, p; power of two.
- PLAINTEXT_WIDTH, 6, log2(p).
- CIPHERTEXT_MODULUS, 1024, q; power of two, q > p.
- CIPHERTEXT_WIDTH, 10, log2(q).
- DIMENSION, 10, number of a/s pairs per ciphertext.
- DIM_WIDTH, 4, element counter width; must satisfy 2^DIM_WIDTH > DIMENSION.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse; begins a decryption.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_a  in  CIPHERTEXT_WIDTH  a_i on beats 0..DIMENSION-1; b on beat DIMENSION.
- in_s  in  CIPHERTEXT_WIDTH  secret key s_i; ignored on the b beat.
- out_valid  out  1  plaintext result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  PLAINTEXT_WIDTH  decrypted plaintext.
- busy  out  1  high from start acceptance until the result handshake completes.

Behaviour:
- Reset: all state is cleared on the clk edge while rst_n=0. State=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0, busy=0. This applies from any state, including mid-operation; any partial accumulation is discarded.
- States: IDLE, ACCUM, BVAL, OUT.
- IDLE:
  - in_ready=0.
  - start=1 -> ACCUM next cycle, acc<=0, cnt<=0, busy<=1.
  - in_valid in IDLE is ignored, including when it coincides with start.
- ACCUM:
  - in_ready=1.
  - Each accepted beat: acc <= (acc + in_a*in_s) mod q. The product is truncated to CIPHERTEXT_WIDTH bits, so all arithmetic wraps naturally. cnt <= cnt+1.
  - Move to BVAL on the beat where cnt==DIMENSION-1.
  - One beat per cycle max; no bubbles required.
- BVAL:
  - in_ready=1.
  - On accept: diff = (in_a - acc) mod q.
  - out_data <= ((diff + q/(2p)) >> (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH)), truncated to PLAINTEXT_WIDTH. Rounding past p-1 therefore wraps to 0.
  - out_valid<=1; go to OUT.
  - Latency: result valid the cycle after the b beat is accepted.
- OUT:
  - in_ready=0.
  - out_data and out_valid are held stable until out_ready=1.
  - On handshake: out_valid<=0, busy<=0, return to IDLE. A new start is honoured no earlier than the cycle after returning to IDLE.
- start is ignored in every state except IDLE.
- DIMENSION=1 is legal: ACCUM takes a single beat.

Optional Feature:
- Macro: LWE_DECRYPT_NOISE_MON_EN.
- When defined, add two outputs:
  - noise_out (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH+1 bits): signed residual diff - out_data*(q/p), taken mod q and sign-extended. Range is -q/(2p) .. q/(2p)-1.
  - noise_warn (1 bit): high when |noise_out| >= q/(4p).
- Both new outputs are registered together with out_data, held in OUT, and reset to 0.
- When the macro is undefined, neither port nor the related logic exists, and all other behaviour is identical.

Test Plan:
- All s_i=0, b=80 -> out_data=5, out_valid exactly one cycle after the b beat, busy drops after out_ready.
- a_i=1 and s_i=1 for all 10 beats (acc=10), b=58 -> diff=48, out_data=3.
- a_i=1023 and s_i=1 for all 10 beats (acc=1014), b=1010 -> diff=1020, out_data=0 (rounding wrap). Same inputs with b=1005 -> diff=1015, out_data=63.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_data stable, in_ready=0, a start pulse during OUT is ignored. Then out_ready=1 -> out_valid=0 and busy=0 next cycle.
- Reset mid-op: rst_n=0 for 1 cycle after 4 ACCUM beats -> the next cycle shows out_valid=0, busy=0, in_ready=0. A fresh decryption (case 2) then yields out_data=3.
- With LWE_DECRYPT_NOISE_MON_EN: diff=48+5=53 -> out_data=3, noise_out=+5, noise_warn=1. diff=50 -> noise_out=+2, noise_warn=0.
